// File: rtl/alu_pkg.sv
// Shared op codes, FSM state type and shift helpers for the execute-stage ALU.
package alu_pkg;

   typedef logic [3:0] alu_op_t;

   localparam alu_op_t OP_AND     = 4'b0000;
   localparam alu_op_t OP_OR      = 4'b0001;
   localparam alu_op_t OP_ADD     = 4'b0010;
   localparam alu_op_t OP_XOR     = 4'b0100;
   localparam alu_op_t OP_SUB     = 4'b0110;
   localparam alu_op_t OP_EQ      = 4'b1000;
   localparam alu_op_t OP_PASS_B  = 4'b1001;
   localparam alu_op_t OP_SLT     = 4'b1010;
   localparam alu_op_t OP_ADD_ALT = 4'b1011;
   localparam alu_op_t OP_SLL     = 4'b1100;
   localparam alu_op_t OP_SRL     = 4'b1101;
   localparam alu_op_t OP_SRA     = 4'b1110;
   localparam alu_op_t OP_SLT_ALT = 4'b1111;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} exec_state_t;

   // Encoded so that the low two bits of a shift op code map directly.
   typedef enum logic [1:0] {SH_SLL = 2'b00, SH_SRL = 2'b01, SH_SRA = 2'b10} shift_kind_t;

   function automatic logic is_shift(alu_op_t op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Operation/result bus between the ID/EX register, the ALU and the EX/MEM register.
interface alu_exec_unit_if #(parameter int WIDTH = 32);
   import alu_pkg::*;

   // A transfer happens on a rising edge where Valid && Ready; Valid must not
   // depend on Ready, and the payload is only meaningful while Valid is high.
   logic             InValid;
   logic             InReady;
   alu_op_t          Operation;
   logic [WIDTH-1:0] SrcA;
   logic [WIDTH-1:0] SrcB;
   logic             Flush;
   logic             OutValid;
   logic             OutReady;
   logic [WIDTH-1:0] ALUResult;
   logic             Zero;

   modport master (
      output InValid, Operation, SrcA, SrcB, Flush, OutReady,
      input  InReady, OutValid, ALUResult, Zero
   );

   modport slave (
      input  InValid, Operation, SrcA, SrcB, Flush, OutReady,
      output InReady, OutValid, ALUResult, Zero
   );

endinterface

// File: rtl/alu_iter_shifter.sv
// Iterative shifter: one bit per clock; done_o marks the edge that makes the final shift.
module alu_iter_shifter
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load_i,
   input  logic               kill_i,
   input  logic [WIDTH-1:0]   operand_i,
   input  logic [SHAMT_W-1:0] shamt_i,
   input  shift_kind_t        kind_i,
   output logic               done_o,
   output logic [WIDTH-1:0]   result_o
);

   logic [WIDTH-1:0]   data_q;
   logic [SHAMT_W-1:0] count_q;
   shift_kind_t        kind_q;
   logic [WIDTH-1:0]   shifted;

   always_comb begin
      shifted = data_q;
      case (kind_q)
         SH_SLL:  shifted = {data_q[WIDTH-2:0], 1'b0};
         SH_SRL:  shifted = {1'b0, data_q[WIDTH-1:1]};
         default: shifted = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      endcase
   end

   assign done_o   = (count_q == SHAMT_W'(1));
   assign result_o = shifted;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q  <= '0;
         count_q <= '0;
         kind_q  <= SH_SLL;
      end else if (kill_i) begin
         count_q <= '0;
      end else if (load_i) begin
         data_q  <= operand_i;
         count_q <= shamt_i;
         kind_q  <= kind_i;
      end else if (count_q != '0) begin
         data_q  <= shifted;
         count_q <= count_q - SHAMT_W'(1);
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle datapath inline, shifts delegated to the iterative shifter.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic        clk,
   input  logic        reset,
   alu_exec_unit_if.slave bus,
   output exec_state_t state_o
);

   exec_state_t        state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q, zero_d;
   logic [WIDTH-1:0]   alu_res;
   logic               alu_zero;
   logic [SHAMT_W-1:0] shamt;
   logic               accept;
   logic               load_shift;
   logic               sh_done;
   logic [WIDTH-1:0]   sh_result;

   assign shamt      = bus.SrcB[SHAMT_W-1:0];
   assign bus.InReady = (state_q == IDLE) && !bus.Flush;
   assign accept     = bus.InValid && bus.InReady;
   assign load_shift = accept && is_shift(bus.Operation) && (shamt != '0);

   // Shift codes only reach this datapath with a zero shift amount.
   always_comb begin
      alu_res = '0;
      case (bus.Operation)
         OP_AND:                 alu_res = bus.SrcA & bus.SrcB;
         OP_OR:                  alu_res = bus.SrcA | bus.SrcB;
         OP_ADD, OP_ADD_ALT:     alu_res = bus.SrcA + bus.SrcB;
         OP_XOR:                 alu_res = bus.SrcA ^ bus.SrcB;
         OP_SUB, OP_EQ:          alu_res = bus.SrcA - bus.SrcB;
         OP_PASS_B:              alu_res = bus.SrcB;
         OP_SLT, OP_SLT_ALT:     alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
         OP_SLL, OP_SRL, OP_SRA: alu_res = bus.SrcA;
         default:                alu_res = '0;
      endcase
      alu_zero = (bus.Operation == OP_EQ) ? (bus.SrcA == bus.SrcB) : (alu_res == '0);
   end

   alu_iter_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) u_shifter (
      .clk       (clk),
      .reset     (reset),
      .load_i    (load_shift),
      .kill_i    (bus.Flush),
      .operand_i (bus.SrcA),
      .shamt_i   (shamt),
      .kind_i    (shift_kind_t'(bus.Operation[1:0])),
      .done_o    (sh_done),
      .result_o  (sh_result)
   );

   always_comb begin
      state_d  = state_q;
      result_d = result_q;
      zero_d   = zero_q;
      case (state_q)
         IDLE: begin
            if (load_shift) begin
               state_d = SHIFT;
            end else if (accept) begin
               state_d  = DONE;
               result_d = alu_res;
               zero_d   = alu_zero;
            end
         end
         SHIFT: begin
            if (sh_done) begin
               state_d  = DONE;
               result_d = sh_result;
               zero_d   = (sh_result == '0);
            end
         end
         DONE: begin
            if (bus.OutReady) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A flush discards whatever is in flight or held, including a pending handshake.
      if (bus.Flush) state_d = IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         result_q <= '0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
      end
   end

   assign bus.OutValid  = (state_q == DONE);
   assign bus.ALUResult = result_q;
   assign bus.Zero      = zero_q;
   assign state_o       = state_q;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Execute-stage ALU. It consumes the 4-bit Operation code produced by the ALU controller, plus two operands from the ID/EX register.
- Single-cycle ops (logic, add/sub, compare, pass) complete in 1 cycle. Shifts run on an iterative 1-bit-per-cycle shifter.
- Valid/ready handshake on the input and output sides, so the hazard unit can stall on multi-cycle shifts.
- Result and branch flag are registered and held until the downstream stage (EX/MEM) accepts them.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SHAMT_W, $clog2(WIDTH) (5), width of the shift-amount field taken from SrcB[SHAMT_W-1:0].

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- InValid  in  1  upstream presents a valid operation.
- InReady  out  1  unit can accept an operation this cycle.
- Operation  in  4  ALU op code from the ALU controller.
- SrcA  in  WIDTH  operand A (rs1 or PC).
- SrcB  in  WIDTH  operand B (rs2 or immediate).
- Flush  in  1  synchronous kill of any in-flight or held operation.
- OutValid  out  1  ALUResult/Zero valid.
- OutReady  in  1  downstream accepts the result.
- ALUResult  out  WIDTH  registered result.
- Zero  out  1  registered flag: 1 when the result is all zeros; for EQ, 1 when SrcA==SrcB.

Behaviour:
- Op codes (package constants):
  - 0000 AND; 0001 OR; 0010 ADD; 0100 XOR; 0110 SUB.
  - 1000 EQ: result = SrcA-SrcB, Zero = (SrcA==SrcB).
  - 1001 PASS_B (LUI); 1010 SLT; 1011 ADD; 1111 SLT.
  - 1100 SLL; 1101 SRL; 1110 SRA.
  - Any other code: result 0, Zero 1, single-cycle.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH, no overflow flag. SLT is a signed compare, result zero-extended (0 or 1).
- Zero for non-EQ ops = (ALUResult == 0).
- States: IDLE, SHIFT, DONE.
- Reset: state IDLE, OutValid 0, ALUResult 0, Zero 0, shift count 0. InReady = 1 after reset.
- InReady = 1 only in IDLE and Flush=0. An operation is accepted on an edge where InValid && InReady.
- IDLE, accept of a non-shift op, or a shift with shamt==0: compute combinationally, register result, go to DONE. OutValid is high the cycle after acceptance (latency 1).
- IDLE, accept of a shift with shamt k>0:
  - Load SrcA into the shift register, count = k, latch the shift type, go to SHIFT.
  - Each edge in SHIFT shifts 1 bit (SLL fills 0; SRL fills 0; SRA fills the MSB) and decrements count.
  - On the edge where count goes 1->0, go to DONE with the result. OutValid rises k cycles after acceptance.
- DONE: OutValid=1. ALUResult/Zero stay stable until OutValid && OutReady, then go to IDLE with OutValid=0.
  - There is no accept in the same cycle as the output handshake; throughput is 1 op per 2 cycles minimum.
- Flush=1 on an edge, in any state: go to IDLE, clear OutValid and count. ALUResult is not required to be cleared.
  - Flush and InValid together: flush wins, nothing accepted.
  - Flush and OutReady in DONE: treated as flush; the result is discarded.
- Reset asserted mid-shift: immediate return to reset values; no partial result is ever presented.
- Operand/Operation inputs are sampled only on the accept edge and may change freely afterward.

Decomposition:
- Package alu_pkg:
  - typedef alu_op_t (4-bit) with the op constants above.
  - typedef exec_state_t {IDLE, SHIFT, DONE}.
  - Helper function is_shift(alu_op_t).
- One sub-module, alu_iter_shifter: loads operand/shamt/type, shifts 1 bit per cycle, asserts done.
- The single-cycle datapath stays inline in alu_exec_unit.

Test Plan:
- Reset: hold reset -> OutValid=0, ALUResult=0, InReady=1. Assert reset mid-SHIFT (shamt 20, cycle 5) -> OutValid never rises, InReady=1 next cycle.
- ADD 0xFFFFFFFF + 0x00000001 (op 0010) -> 1 cycle later OutValid=1, ALUResult=0, Zero=1. SUB 5-7 (0110) -> 0xFFFFFFFE, Zero=0.
- EQ 0x1234 vs 0x1234 (1000) -> Zero=1. SLT -1 vs 1 (1010) -> result 1. PASS_B 0xABCDE000 (1001) -> 0xABCDE000.
- SRA 0x80000000 by 31 (1110) -> OutValid exactly 31 cycles after accept, result 0xFFFFFFFF, InReady=0 throughout. SLL 0x1 by 0 -> latency 1, result 0x1.
- Backpressure: OutReady=0 for 10 cycles in DONE -> ALUResult stable, InValid ignored; OutReady=1 -> IDLE next cycle, new op accepted.
- Flush during SHIFT (SRL by 16, flush at cycle 4) -> OutValid stays 0, IDLE next cycle. Flush+InValid in IDLE -> op not accepted.
